decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_pkg.sv | 71 +++++++
 rtl/instr_decode_comb.sv | 178 +++++++++++++++++
 rtl/decode_stage.sv | 144 ++++++++++++++
 tb/tb_decode_stage.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared constants for the RV32 decode stage: opcodes, ALU operation codes,
// out_ctrl bit positions and immediate extraction helpers.
package decode_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,  ALU_SUB   = 5'd1,  ALU_XOR    = 5'd2,  ALU_OR    = 5'd3,
        ALU_AND    = 5'd4,  ALU_SLL   = 5'd5,  ALU_SRL    = 5'd6,  ALU_SRA   = 5'd7,
        ALU_SLT    = 5'd8,  ALU_SLTU  = 5'd9,  ALU_ADDI   = 5'd10, ALU_XORI  = 5'd11,
        ALU_ORI    = 5'd12, ALU_ANDI  = 5'd13, ALU_SLLI   = 5'd14, ALU_SRLI  = 5'd15,
        ALU_SRAI   = 5'd16, ALU_SLTI  = 5'd17, ALU_SLTIU  = 5'd18, ALU_MUL   = 5'd19,
        ALU_MULH   = 5'd20, ALU_MULHSU = 5'd21, ALU_MULHU = 5'd22, ALU_LUI   = 5'd23,
        ALU_AUIPC  = 5'd24
    } alu_op_e;

    localparam int CTRL_W         = 12;
    localparam int CTRL_REG_WRITE = 0;
    localparam int CTRL_ALU_SRC   = 1;
    localparam int CTRL_IS_BRANCH = 2;
    localparam int CTRL_JAL       = 3;
    localparam int CTRL_JALR      = 4;
    localparam int CTRL_IS_LOAD   = 5;
    localparam int CTRL_IS_STORE  = 6;
    localparam int CTRL_IS_DIV    = 7;
    localparam int CTRL_IS_MUL    = 8;
    localparam int CTRL_ILLEGAL   = 9;
    localparam int CTRL_LUI       = 10;
    localparam int CTRL_AUIPC     = 11;

    typedef struct packed {
        logic [31:0]       imm;
        alu_op_e           alu_op;
        logic [2:0]        div_op;
        logic [2:0]        funct3;
        logic [CTRL_W-1:0] ctrl;
    } dec_fields_t;

    function automatic logic [31:0] imm_i(input logic [31:0] w);
        return {{20{w[31]}}, w[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] w);
        return {{20{w[31]}}, w[31:25], w[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] w);
        return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] w);
        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] w);
        return {w[31:12], 12'b0};
    endfunction

endpackage

// File: rtl/instr_decode_comb.sv
// Purely combinational RV32I(+M) decoder; any illegal encoding collapses to a
// word with only the illegal ctrl bit set.
module instr_decode_comb import decode_pkg::*; #(
    parameter int REG_AW = 5,
    parameter int M_EXT  = 1
) (
    input  logic [31:0]       instr,
    output logic [REG_AW-1:0] rd,
    output logic [REG_AW-1:0] rs1,
    output logic [REG_AW-1:0] rs2,
    output dec_fields_t       fields
);

    // Register index bits that do not exist in this register file.
    localparam logic [4:0] HI_MASK = 5'((32'h1F << REG_AW) & 32'h1F);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        legal;
    logic        use_rd;
    logic        use_rs1;
    logic        use_rs2;
    dec_fields_t f;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        f       = '0;
        legal   = 1'b1;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OPC_OP: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                f.ctrl[CTRL_REG_WRITE] = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'd0:    f.alu_op = ALU_ADD;
                        3'd1:    f.alu_op = ALU_SLL;
                        3'd2:    f.alu_op = ALU_SLT;
                        3'd3:    f.alu_op = ALU_SLTU;
                        3'd4:    f.alu_op = ALU_XOR;
                        3'd5:    f.alu_op = ALU_SRL;
                        3'd6:    f.alu_op = ALU_OR;
                        default: f.alu_op = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'd0) begin
                    f.alu_op = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'd5) begin
                    f.alu_op = ALU_SRA;
                end else if (funct7 == F7_MULDIV && M_EXT != 0) begin
                    if (!funct3[2]) begin
                        f.ctrl[CTRL_IS_MUL] = 1'b1;
                        case (funct3[1:0])
                            2'd0:    f.alu_op = ALU_MUL;
                            2'd1:    f.alu_op = ALU_MULH;
                            2'd2:    f.alu_op = ALU_MULHSU;
                            default: f.alu_op = ALU_MULHU;
                        endcase
                    end else begin
                        f.ctrl[CTRL_IS_DIV] = 1'b1;
                        f.div_op            = funct3;
                    end
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                f.ctrl[CTRL_REG_WRITE] = 1'b1;
                f.ctrl[CTRL_ALU_SRC]   = 1'b1;
                f.imm = imm_i(instr);
                case (funct3)
                    3'd0: f.alu_op = ALU_ADDI;
                    3'd2: f.alu_op = ALU_SLTI;
                    3'd3: f.alu_op = ALU_SLTIU;
                    3'd4: f.alu_op = ALU_XORI;
                    3'd6: f.alu_op = ALU_ORI;
                    3'd7: f.alu_op = ALU_ANDI;
                    3'd1: begin
                        f.alu_op = ALU_SLLI;
                        legal    = (funct7 == F7_BASE);
                    end
                    default: begin
                        f.alu_op = (funct7 == F7_ALT) ? ALU_SRAI : ALU_SRLI;
                        legal    = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                endcase
            end
            OPC_LOAD: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                f.ctrl[CTRL_REG_WRITE] = 1'b1;
                f.ctrl[CTRL_ALU_SRC]   = 1'b1;
                f.ctrl[CTRL_IS_LOAD]   = 1'b1;
                f.imm    = imm_i(instr);
                f.funct3 = funct3;
                legal    = (funct3 != 3'd3) && (funct3 < 3'd6);
            end
            OPC_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                f.ctrl[CTRL_ALU_SRC]  = 1'b1;
                f.ctrl[CTRL_IS_STORE] = 1'b1;
                f.imm    = imm_s(instr);
                f.funct3 = funct3;
                legal    = (funct3 <= 3'd2);
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                f.ctrl[CTRL_IS_BRANCH] = 1'b1;
                f.imm    = imm_b(instr);
                f.funct3 = funct3;
                legal    = (funct3[2:1] != 2'b01);
            end
            OPC_JAL: begin
                use_rd = 1'b1;
                f.ctrl[CTRL_REG_WRITE] = 1'b1;
                f.ctrl[CTRL_JAL]       = 1'b1;
                f.imm = imm_j(instr);
            end
            OPC_JALR: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                f.ctrl[CTRL_REG_WRITE] = 1'b1;
                f.ctrl[CTRL_ALU_SRC]   = 1'b1;
                f.ctrl[CTRL_JALR]      = 1'b1;
                f.imm = imm_i(instr);
                legal = (funct3 == 3'd0);
            end
            OPC_LUI: begin
                use_rd = 1'b1;
                f.ctrl[CTRL_REG_WRITE] = 1'b1;
                f.ctrl[CTRL_ALU_SRC]   = 1'b1;
                f.ctrl[CTRL_LUI]       = 1'b1;
                f.alu_op = ALU_LUI;
                f.imm    = imm_u(instr);
            end
            OPC_AUIPC: begin
                use_rd = 1'b1;
                f.ctrl[CTRL_REG_WRITE] = 1'b1;
                f.ctrl[CTRL_ALU_SRC]   = 1'b1;
                f.ctrl[CTRL_AUIPC]     = 1'b1;
                f.alu_op = ALU_AUIPC;
                f.imm    = imm_u(instr);
            end
            default: legal = 1'b0;
        endcase

        if ((use_rd  && |(instr[11:7]  & HI_MASK)) ||
            (use_rs1 && |(instr[19:15] & HI_MASK)) ||
            (use_rs2 && |(instr[24:20] & HI_MASK))) begin
            legal = 1'b0;
        end

        if (!legal) begin
            f                    = '0;
            f.ctrl[CTRL_ILLEGAL] = 1'b1;
            use_rd               = 1'b0;
            use_rs1              = 1'b0;
            use_rs2              = 1'b0;
        end
    end

    assign rd     = use_rd  ? instr[7 +: REG_AW]  : '0;
    assign rs1    = use_rs1 ? instr[15 +: REG_AW] : '0;
    assign rs2    = use_rs2 ? instr[20 +: REG_AW] : '0;
    assign fields = f;

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: two-entry skid buffer of decoded instructions with a
// divider interlock on the head entry and a saturating illegal-issue counter.
module decode_stage import decode_pkg::*; #(
    parameter int REG_AW = 5,
    parameter int M_EXT  = 1,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    input  logic              div_busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [REG_AW-1:0] out_rd,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2,
    output logic [31:0]       out_imm,
    output logic [4:0]        out_alu_op,
    output logic [2:0]        out_div_op,
    output logic [2:0]        out_funct3,
    output logic [11:0]       out_ctrl,
    output logic [7:0]        illegal_count
);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        dec_fields_t       f;
    } entry_t;

    logic [REG_AW-1:0] dec_rd;
    logic [REG_AW-1:0] dec_rs1;
    logic [REG_AW-1:0] dec_rs2;
    dec_fields_t       dec_fields;
    entry_t            in_ent;
    entry_t            out_ent;

    entry_t      ent0_q, ent0_d;
    entry_t      ent1_q, ent1_d;
    logic [1:0]  count_q, count_d;
    logic        in_ready_q, in_ready_d;
    logic [7:0]  illegal_count_q, illegal_count_d;
    logic        head_stall;
    logic        accept;
    logic        issue;

    instr_decode_comb #(
        .REG_AW (REG_AW),
        .M_EXT  (M_EXT)
    ) u_decode (
        .instr  (in_instr),
        .rd     (dec_rd),
        .rs1    (dec_rs1),
        .rs2    (dec_rs2),
        .fields (dec_fields)
    );

    assign in_ent = '{pc: in_pc, rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2, f: dec_fields};

    always_comb begin
        head_stall      = ent0_q.f.ctrl[CTRL_IS_DIV] && div_busy;
        out_valid       = (count_q != 2'd0) && !head_stall;
        accept          = in_valid && in_ready_q && !flush;
        issue           = out_valid && out_ready;
        ent0_d          = ent0_q;
        ent1_d          = ent1_q;
        count_d         = count_q;
        illegal_count_d = illegal_count_q;

        if (flush) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (accept) begin
                        ent0_d  = in_ent;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (issue && accept) begin
                        ent0_d = in_ent;
                    end else if (issue) begin
                        count_d = 2'd0;
                    end else if (accept) begin
                        ent1_d  = in_ent;
                        count_d = 2'd2;
                    end
                end
                default: begin
                    // Full: in_ready is low, so only the head can leave.
                    if (issue) begin
                        ent0_d  = ent1_q;
                        count_d = 2'd1;
                    end
                end
            endcase
            if (issue && ent0_q.f.ctrl[CTRL_ILLEGAL] && illegal_count_q != 8'hFF) begin
                illegal_count_d = illegal_count_q + 8'd1;
            end
        end

        in_ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q         <= 2'd0;
            in_ready_q      <= 1'b1;
            illegal_count_q <= 8'd0;
        end else begin
            count_q         <= count_d;
            in_ready_q      <= in_ready_d;
            illegal_count_q <= illegal_count_d;
        end
    end

    // Payload needs no reset: it is masked by occupancy on the way out.
    always_ff @(posedge clk) begin
        ent0_q <= ent0_d;
        ent1_q <= ent1_d;
    end

    assign out_ent       = (count_q != 2'd0) ? ent0_q : '0;
    assign in_ready      = in_ready_q;
    assign out_pc        = out_ent.pc;
    assign out_rd        = out_ent.rd;
    assign out_rs1       = out_ent.rs1;
    assign out_rs2       = out_ent.rs2;
    assign out_imm       = out_ent.f.imm;
    assign out_alu_op    = out_ent.f.alu_op;
    assign out_div_op    = out_ent.f.div_op;
    assign out_funct3    = out_ent.f.funct3;
    assign out_ctrl      = out_ent.f.ctrl;
    assign illegal_count = illegal_count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: an RV32I/M (REG_AW=5) and an RV32E without M
// (REG_AW=4, M_EXT=0) instance, each checked against a queue-based reference.
module tb_decode_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, flush, div_busy, out_ready, in_valid_b, out_ready_b;
    logic        div_busy_b;
    logic [31:0] in_instr, in_pc;

    logic        in_ready_a, out_valid_a;
    logic [31:0] out_pc_a, out_imm_a;
    logic [4:0]  out_rd_a, out_rs1_a, out_rs2_a, out_alu_op_a;
    logic [2:0]  out_div_op_a, out_funct3_a;
    logic [11:0] out_ctrl_a;
    logic [7:0]  illegal_count_a;

    logic        in_ready_b, out_valid_b;
    logic [31:0] out_pc_b, out_imm_b;
    logic [3:0]  out_rd_b, out_rs1_b, out_rs2_b;
    logic [4:0]  out_alu_op_b;
    logic [2:0]  out_div_op_b, out_funct3_b;
    logic [11:0] out_ctrl_b;
    logic [7:0]  illegal_count_b;

    assign div_busy_b = 1'b0;

    decode_stage #(.REG_AW(5), .M_EXT(1), .PC_W(32)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .div_busy(div_busy),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_pc(out_pc_a),
        .out_rd(out_rd_a), .out_rs1(out_rs1_a), .out_rs2(out_rs2_a),
        .out_imm(out_imm_a), .out_alu_op(out_alu_op_a), .out_div_op(out_div_op_a),
        .out_funct3(out_funct3_a), .out_ctrl(out_ctrl_a), .illegal_count(illegal_count_a)
    );

    decode_stage #(.REG_AW(4), .M_EXT(0), .PC_W(32)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .div_busy(div_busy_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_pc(out_pc_b),
        .out_rd(out_rd_b), .out_rs1(out_rs1_b), .out_rs2(out_rs2_b),
        .out_imm(out_imm_b), .out_alu_op(out_alu_op_b), .out_div_op(out_div_op_b),
        .out_funct3(out_funct3_b), .out_ctrl(out_ctrl_b), .illegal_count(illegal_count_b)
    );

    typedef struct packed {
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [4:0]  alu;
        logic [2:0]  div, f3;
        logic [11:0] ctrl;
    } exp_t;

    typedef struct packed {
        logic [31:0] pc;
        exp_t        e;
    } ent_t;

    ent_t qa[$];
    ent_t qb[$];
    int   cnt_a = 0, cnt_b = 0;
    int   errors = 0, checks = 0;
    logic exp_rdy_a, exp_vld_a, exp_rdy_b, exp_vld_b;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decoder written from the ISA tables, independent of the RTL.
    function automatic exp_t ref_dec(input logic [31:0] w, input int aw, input bit mext);
        exp_t        e;
        bit          ok, ud, u1, u2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        int          sx;
        int unsigned alu_r[8];
        int unsigned alu_i[8];
        e = '0; ok = 1; ud = 0; u1 = 0; u2 = 0;
        f3 = w[14:12];
        f7 = w[31:25];
        alu_r = '{0, 5, 8, 9, 2, 6, 3, 4};
        alu_i = '{10, 14, 17, 18, 11, 15, 12, 13};
        case (w[6:0])
            7'b0110011: begin
                ud = 1; u1 = 1; u2 = 1; e.ctrl[0] = 1;
                if (f7 == 7'h00) e.alu = 5'(alu_r[f3]);
                else if (f7 == 7'h20 && f3 == 0) e.alu = 1;
                else if (f7 == 7'h20 && f3 == 5) e.alu = 7;
                else if (f7 == 7'h01 && mext) begin
                    if (f3 < 4) begin e.alu = 5'(19 + f3); e.ctrl[8] = 1; end
                    else begin e.div = f3; e.ctrl[7] = 1; end
                end else ok = 0;
            end
            7'b0010011: begin
                ud = 1; u1 = 1; e.ctrl[0] = 1; e.ctrl[1] = 1;
                sx = $signed(w[31:20]); e.imm = sx;
                if (f3 == 1 && f7 != 0) ok = 0;
                else if (f3 == 5 && f7 == 7'h20) e.alu = 16;
                else if (f3 == 5 && f7 != 0) ok = 0;
                else e.alu = 5'(alu_i[f3]);
            end
            7'b0000011: begin
                ud = 1; u1 = 1; e.ctrl[0] = 1; e.ctrl[1] = 1; e.ctrl[5] = 1;
                sx = $signed(w[31:20]); e.imm = sx; e.f3 = f3;
                ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
            end
            7'b0100011: begin
                u1 = 1; u2 = 1; e.ctrl[1] = 1; e.ctrl[6] = 1;
                sx = $signed({w[31:25], w[11:7]}); e.imm = sx; e.f3 = f3;
                ok = (f3 <= 2);
            end
            7'b1100011: begin
                u1 = 1; u2 = 1; e.ctrl[2] = 1;
                sx = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0}); e.imm = sx; e.f3 = f3;
                ok = !(f3 == 2 || f3 == 3);
            end
            7'b1101111: begin
                ud = 1; e.ctrl[0] = 1; e.ctrl[3] = 1;
                sx = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0}); e.imm = sx;
            end
            7'b1100111: begin
                ud = 1; u1 = 1; e.ctrl[0] = 1; e.ctrl[1] = 1; e.ctrl[4] = 1;
                sx = $signed(w[31:20]); e.imm = sx;
                ok = (f3 == 0);
            end
            7'b0110111: begin
                ud = 1; e.ctrl[0] = 1; e.ctrl[1] = 1; e.ctrl[10] = 1; e.alu = 23;
                e.imm = w & 32'hFFFF_F000;
            end
            7'b0010111: begin
                ud = 1; e.ctrl[0] = 1; e.ctrl[1] = 1; e.ctrl[11] = 1; e.alu = 24;
                e.imm = w & 32'hFFFF_F000;
            end
            default: ok = 0;
        endcase
        if (aw < 5) begin
            if ((ud && (w[11:7] >> aw) != 0) || (u1 && (w[19:15] >> aw) != 0) ||
                (u2 && (w[24:20] >> aw) != 0)) ok = 0;
        end
        if (ok) begin
            e.rd  = ud ? w[11:7]  : 5'd0;
            e.rs1 = u1 ? w[19:15] : 5'd0;
            e.rs2 = u2 ? w[24:20] : 5'd0;
        end else begin
            e = '0;
            e.ctrl[9] = 1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        logic [6:0]  ops[9];
        ops = '{7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h37, 7'h17};
        w = $urandom;
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
        endcase
        if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 8)];
        if ($urandom_range(0, 1) != 0) begin w[11] = 0; w[19] = 0; w[24] = 0; end
        return w;
    endfunction

    task automatic cyc_begin(input logic r, input logic iv, input logic [31:0] ins,
                             input logic [31:0] pcv, input logic ordy, input logic fl,
                             input logic db, input logic ivb, input logic ordyb);
        logic [127:0] ea, eb;
        @(negedge clk);
        rst = r; in_valid = iv; in_instr = ins; in_pc = pcv; out_ready = ordy;
        flush = fl; div_busy = db; in_valid_b = ivb; out_ready_b = ordyb;
        #1;
        exp_rdy_a = (qa.size() < 2);
        exp_rdy_b = (qb.size() < 2);
        exp_vld_a = 1'b0;
        ea = '0;
        if (qa.size() > 0) begin
            exp_vld_a = !(qa[0].e.ctrl[7] && db);
            ea = 128'(qa[0]);
        end
        exp_vld_b = (qb.size() > 0);
        eb = '0;
        if (qb.size() > 0) begin
            eb = 128'({qb[0].pc, qb[0].e.rd[3:0], qb[0].e.rs1[3:0], qb[0].e.rs2[3:0],
                       qb[0].e.imm, qb[0].e.alu, qb[0].e.div, qb[0].e.f3, qb[0].e.ctrl});
        end
        chk("a_in_ready", in_ready_a, exp_rdy_a);
        chk("a_out_valid", out_valid_a, exp_vld_a);
        chk("a_fields", {out_pc_a, out_rd_a, out_rs1_a, out_rs2_a, out_imm_a,
                         out_alu_op_a, out_div_op_a, out_funct3_a, out_ctrl_a}, ea);
        chk("a_illegal_count", illegal_count_a, cnt_a);
        chk("b_in_ready", in_ready_b, exp_rdy_b);
        chk("b_out_valid", out_valid_b, exp_vld_b);
        chk("b_fields", {out_pc_b, out_rd_b, out_rs1_b, out_rs2_b, out_imm_b,
                         out_alu_op_b, out_div_op_b, out_funct3_b, out_ctrl_b}, eb);
        chk("b_illegal_count", illegal_count_b, cnt_b);
    endtask

    task automatic cyc_end();
        if (rst) begin
            qa.delete(); qb.delete(); cnt_a = 0; cnt_b = 0;
        end else if (flush) begin
            qa.delete(); qb.delete();
        end else begin
            if (exp_vld_a && out_ready) begin
                if (qa[0].e.ctrl[9] && cnt_a < 255) cnt_a++;
                void'(qa.pop_front());
            end
            if (in_valid && exp_rdy_a) qa.push_back('{pc: in_pc, e: ref_dec(in_instr, 5, 1'b1)});
            if (exp_vld_b && out_ready_b) begin
                if (qb[0].e.ctrl[9] && cnt_b < 255) cnt_b++;
                void'(qb.pop_front());
            end
            if (in_valid_b && exp_rdy_b) qb.push_back('{pc: in_pc, e: ref_dec(in_instr, 4, 1'b0)});
        end
        @(posedge clk);
    endtask

    task automatic step(input logic r, input logic iv, input logic [31:0] ins,
                        input logic [31:0] pcv, input logic ordy, input logic fl,
                        input logic db, input logic ivb, input logic ordyb);
        cyc_begin(r, iv, ins, pcv, ordy, fl, db, ivb, ordyb);
        cyc_end();
    endtask

    task automatic idle();
        step(0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 1);
    endtask

    initial begin
        rst = 1; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;
        flush = 0; div_busy = 0; in_valid_b = 0; out_ready_b = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid_a, 1'b0);
        chk("rst_in_ready", in_ready_a, 1'b1);
        chk("rst_fields", {out_pc_a, out_imm_a, out_ctrl_a, out_rd_a}, 128'd0);
        chk("rst_count", illegal_count_a, 8'd0);

        // add x3,x1,x2
        step(0, 1, 32'h002081B3, 32'h100, 1, 0, 0, 0, 1);
        cyc_begin(0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 1);
        chk("add_valid", out_valid_a, 1'b1);
        chk("add_rd", out_rd_a, 5'd3);
        chk("add_rs1", out_rs1_a, 5'd1);
        chk("add_rs2", out_rs2_a, 5'd2);
        chk("add_alu", out_alu_op_a, 5'd0);
        chk("add_regwrite", out_ctrl_a[0], 1'b1);
        cyc_end();

        // lui x5,0x12345
        step(0, 1, 32'h123452B7, 32'h104, 1, 0, 0, 0, 1);
        cyc_begin(0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 1);
        chk("lui_imm", out_imm_a, 32'h12345000);
        chk("lui_alu", out_alu_op_a, 5'd23);
        chk("lui_bit", out_ctrl_a[10], 1'b1);
        chk("lui_rd", out_rd_a, 5'd5);
        cyc_end();

        // div x1,x2,x3 held while the divider is busy
        step(0, 1, 32'h023140B3, 32'h108, 1, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) begin
            cyc_begin(0, 0, 32'h0, 32'h0, 1, 0, 1, 0, 1);
            chk("div_stall", out_valid_a, 1'b0);
            cyc_end();
        end
        cyc_begin(0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 1);
        chk("div_release", out_valid_a, 1'b1);
        chk("div_op", out_div_op_a, 3'd4);
        chk("div_bit", out_ctrl_a[7], 1'b1);
        cyc_end();

        // backpressure with three instructions offered
        step(0, 1, 32'h00100093, 32'h200, 0, 0, 0, 0, 1);
        step(0, 1, 32'h00200113, 32'h204, 0, 0, 0, 0, 1);
        cyc_begin(0, 1, 32'h00300193, 32'h208, 0, 0, 0, 0, 1);
        chk("bp_full_ready", in_ready_a, 1'b0);
        cyc_end();
        cyc_begin(0, 1, 32'h00300193, 32'h208, 1, 0, 0, 0, 1);
        chk("bp_first_pc", out_pc_a, 32'h200);
        cyc_end();
        cyc_begin(0, 1, 32'h00300193, 32'h208, 1, 0, 0, 0, 1);
        chk("bp_second_pc", out_pc_a, 32'h204);
        chk("bp_ready_again", in_ready_a, 1'b1);
        cyc_end();
        cyc_begin(0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 1);
        chk("bp_third_pc", out_pc_a, 32'h208);
        chk("bp_third_rd", out_rd_a, 5'd3);
        cyc_end();
        cyc_begin(0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 1);
        chk("bp_drained", out_valid_a, 1'b0);
        cyc_end();

        // flush with both entries full, then flush dropping an incoming transfer
        step(0, 1, 32'h00100093, 32'h300, 0, 0, 0, 0, 1);
        step(0, 1, 32'h00200113, 32'h304, 0, 0, 0, 0, 1);
        step(0, 1, 32'h00300193, 32'h308, 0, 1, 0, 0, 1);
        cyc_begin(0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 1);
        chk("flush_valid", out_valid_a, 1'b0);
        chk("flush_ready", in_ready_a, 1'b1);
        cyc_end();
        step(0, 1, 32'h00100093, 32'h310, 0, 0, 0, 0, 1);
        step(0, 1, 32'h00200113, 32'h314, 0, 1, 0, 0, 1);
        cyc_begin(0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 1);
        chk("flush_drop", out_valid_a, 1'b0);
        cyc_end();

        // illegal counter saturation
        for (int i = 0; i < 260; i++) step(0, 1, 32'h0, 32'h400, 1, 0, 0, 0, 1);
        idle();
        cyc_begin(0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 1);
        chk("sat_count", illegal_count_a, 8'd255);
        cyc_end();

        // reset while both entries are occupied
        step(0, 1, 32'h00100093, 32'h500, 0, 0, 0, 0, 1);
        step(0, 1, 32'h00200113, 32'h504, 0, 0, 0, 0, 1);
        step(1, 1, 32'h00300193, 32'h508, 0, 0, 0, 0, 1);
        cyc_begin(0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 1);
        chk("rst_mid_valid", out_valid_a, 1'b0);
        chk("rst_mid_ready", in_ready_a, 1'b1);
        chk("rst_mid_count", illegal_count_a, 8'd0);
        cyc_end();

        // RV32E instance: x17 source and MUL/DIV without the M extension
        step(0, 0, 32'h011000B3, 32'h600, 1, 0, 0, 1, 1);
        cyc_begin(0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 1);
        chk("e_illegal", out_ctrl_b[9], 1'b1);
        chk("e_regwrite", out_ctrl_b[0], 1'b0);
        cyc_end();
        cyc_begin(0, 0, 32'h023140B3, 32'h604, 1, 0, 0, 1, 1);
        chk("e_count1", illegal_count_b, 8'd1);
        cyc_end();
        cyc_begin(0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 1);
        chk("e_nomext", out_ctrl_b, 12'h200);
        cyc_end();

        // randomized traffic on both instances
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, rnd_instr(), $urandom,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 6);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
